// File: rtl/display_scan_ctrl.sv
// Scan engine for a 4-digit 7-segment display: digit index, active-low anodes with
// per-slot blanking dead-time, frame-synchronous value update and leading-zero blanking.
module display_scan_ctrl #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] hex_num_in,
   input  logic        lz_blank,
   output logic [1:0]  digit,
   output logic [15:0] hex_num_4digit,
   output logic [3:0]  anodes,
   output logic        frame_tick
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] TERM_CNT   = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      digit_q, digit_d;
   logic [15:0]     hex_q, hex_d;
   logic [15:0]     pend_q, pend_d;
   logic            pend_valid_q, pend_valid_d;
   logic [3:0]      anodes_q, anodes_d;
   logic            tick_q;
   logic            rollover;
   logic [3:0]      upper_zero;

   // upper_zero[i]: nibbles i..3 of the value being displayed next are all zero
   for (genvar gi = 0; gi < 4; gi++) begin : g_lz
      assign upper_zero[gi] = ~|hex_d[15:4*gi];
   end

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      digit_d      = digit_q;
      rollover     = 1'b0;
      if (!en) begin
         state_d = IDLE;
         presc_d = '0;
         digit_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               presc_d = '0;
               state_d = (BLANK_CYCLES == 0) ? ON : BLANK;
            end
            BLANK: begin
               presc_d = presc_q + PW'(1);
               if (presc_q == BLANK_LAST) state_d = ON;
            end
            ON: begin
               if (presc_q == TERM_CNT) begin
                  presc_d  = '0;
                  digit_d  = digit_q + 2'd1;
                  state_d  = (BLANK_CYCLES == 0) ? ON : BLANK;
                  rollover = (digit_q == 2'd3);
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // While idle nothing is lit, so a load can be shown immediately without tearing
   always_comb begin
      hex_d        = hex_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (state_q == IDLE) begin
         if (load) begin
            hex_d        = hex_num_in;
            pend_valid_d = 1'b0;
         end
      end else if (rollover) begin
         if (load)
            hex_d = hex_num_in;
         else if (pend_valid_q)
            hex_d = pend_q;
         pend_valid_d = 1'b0;
      end else if (load) begin
         pend_d       = hex_num_in;
         pend_valid_d = 1'b1;
      end
   end

   always_comb begin
      anodes_d = 4'b1111;
      if (state_d == ON)
         anodes_d[digit_d] = ~((digit_d == 2'd0) | ~lz_blank | ~upper_zero[digit_d]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         digit_q      <= 2'd0;
         hex_q        <= 16'h0000;
         pend_q       <= 16'h0000;
         pend_valid_q <= 1'b0;
         anodes_q     <= 4'b1111;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         digit_q      <= digit_d;
         hex_q        <= hex_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         anodes_q     <= anodes_d;
         tick_q       <= rollover;
      end
   end

   assign digit          = digit_q;
   assign hex_num_4digit = hex_q;
   assign anodes         = anodes_q;
   assign frame_tick     = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl: two instances (blanking 2 and 0 cycles)
// checked every cycle against a position-in-frame reference model.
module tb_display_scan_ctrl;

   localparam int R     = 8;
   localparam int FRAME = 4 * R;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, load, lz;
   logic [15:0] hin;
   logic [1:0]  dig0, dig1;
   logic [15:0] hv0, hv1;
   logic [3:0]  an0, an1;
   logic        ft0, ft1;

   display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .en(en), .load(load), .hex_num_in(hin), .lz_blank(lz),
      .digit(dig0), .hex_num_4digit(hv0), .anodes(an0), .frame_tick(ft0));

   display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .en(en), .load(load), .hex_num_in(hin), .lz_blank(lz),
      .digit(dig1), .hex_num_4digit(hv1), .anodes(an1), .frame_tick(ft1));

   int n_run  = 0;
   int n_fail = 0;

   // Reference: each instance is either dark or at position pos since it was enabled
   bit          m_act  [2];
   int          m_pos  [2];
   logic [15:0] m_val  [2];
   logic [15:0] m_pend [2];
   bit          m_pv   [2];
   bit          m_lz   [2];
   int          m_blank[2] = '{2, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic model_edge(input int k, input bit r, input bit e, input bit l,
                             input logic [15:0] h, input bit z);
      m_lz[k] = z;
      if (r) begin
         m_act[k] = 0; m_pos[k] = 0; m_val[k] = 16'h0; m_pv[k] = 0;
      end else if (!m_act[k]) begin
         if (l) begin m_val[k] = h; m_pv[k] = 0; end
         m_act[k] = e;
         m_pos[k] = 0;
      end else if (!e) begin
         if (l) begin m_pend[k] = h; m_pv[k] = 1; end
         m_act[k] = 0;
         m_pos[k] = 0;
      end else begin
         m_pos[k]++;
         if (m_pos[k] % FRAME == 0) begin
            if (l) m_val[k] = h;
            else if (m_pv[k]) m_val[k] = m_pend[k];
            m_pv[k] = 0;
         end else if (l) begin
            m_pend[k] = h; m_pv[k] = 1;
         end
      end
   endtask

   task automatic compare(input int k, input logic [1:0] d, input logic [15:0] v,
                          input logic [3:0] a, input logic t);
      int          ed, ph;
      logic [3:0]  ea;
      bit          et;
      ea = 4'b1111; ed = 0; et = 0;
      if (m_act[k]) begin
         ed = (m_pos[k] / R) % 4;
         ph = m_pos[k] % R;
         if (ph >= m_blank[k] && !(m_lz[k] && ed > 0 && (m_val[k] >> (4 * ed)) == 0))
            ea[ed] = 1'b0;
         et = (m_pos[k] > 0) && (m_pos[k] % FRAME == 0);
      end
      check($sformatf("digit%0d", k),  {30'd0, d},  ed);
      check($sformatf("value%0d", k),  {16'd0, v},  {16'd0, m_val[k]});
      check($sformatf("anodes%0d", k), {28'd0, a},  {28'd0, ea});
      check($sformatf("tick%0d", k),   {31'd0, t},  {31'd0, et});
   endtask

   task automatic step(input bit r, input bit e, input bit l, input logic [15:0] h, input bit z);
      rst = r; en = e; load = l; hin = h; lz = z;
      if (l) $display("[TB] t=%0t load %h en=%0b rst=%0b", $time, h, e, r);
      @(posedge clk);
      model_edge(0, r, e, l, h, z);
      model_edge(1, r, e, l, h, z);
      #1;
      compare(0, dig0, hv0, an0, ft0);
      compare(1, dig1, hv1, an1, ft1);
   endtask

   task automatic run_to(input int tgt, input bit z);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (m_act[0] && (m_pos[0] % FRAME) == tgt) break;
         step(0, 1, 0, 16'h0, z);
      end
   endtask

   task automatic run(input int n, input bit z);
      for (int i = 0; i < n; i++) step(0, 1, 0, 16'h0, z);
   endtask

   initial begin
      logic [15:0] rv;
      bit          lzr;
      int          ticks;
      rst = 1; en = 0; load = 0; hin = 0; lz = 0;
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      run(40, 0);
      run_to(10, 0); step(0, 1, 1, 16'hABCD, 0);
      run_to(31, 0); step(0, 1, 0, 16'h0, 0);
      run_to(20, 0); step(0, 1, 1, 16'h1234, 0);
      run_to(25, 0); step(0, 1, 1, 16'h5678, 0);
      run_to(31, 0); step(0, 1, 0, 16'h0, 0);
      run_to(31, 1); step(0, 1, 1, 16'h00F0, 1);
      run(70, 1);
      run_to(31, 1); step(0, 1, 1, 16'h0000, 1);
      run(40, 1);
      run_to(19, 0); step(0, 0, 0, 16'h0, 0);
      step(0, 0, 1, 16'h1111, 0);
      step(0, 0, 0, 16'h0, 0);
      run(20, 0);
      step(0, 1, 1, 16'hBEEF, 0);
      run(3, 0);
      step(1, 1, 0, 16'h0, 0);
      run(40, 0);

      // frame_tick cadence over four full frames of uninterrupted scanning
      ticks = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         step(0, 1, 0, 16'h0, 0);
         ticks += ft0;
      end
      check("tick_count", ticks, 4);

      lzr = 0;
      for (int i = 0; i < 3000; i++) begin
         rv = 16'($urandom);
         for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 0) rv[4*n +: 4] = 4'h0;
         if ($urandom_range(0, 99) == 0) lzr = ~lzr;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 59) != 0,
              $urandom_range(0, 9) == 0, rv, lzr);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
